// File: rtl/reduce_stream.sv
// reduce_stream: streaming packet reducer that folds PORT_NUM operand words per beat
// with AND / OR / XOR / RAND across beats until a last beat, then presents one result.
//
// Parameters:
//   PORT_NUM  operand ports per beat (2..8)
//   WIDTH     bits per operand and result (1..32)
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    packed operands, port i = in_data[i*WIDTH +: WIDTH]
//   in_op      00 AND, 01 OR, 10 XOR, 11 RAND (AND of every bit, 1-bit result)
//   in_last    beat closes the current packet
//   in_valid   beat present
//   in_ready   beat accepted when in_valid && in_ready
//   out_data   packet result
//   out_beats  beats in packet, saturating at 255
//   out_valid  result present
//   out_ready  consumer accepts result
//   out_parity ^out_data, only when REDUCE_STREAM_PARITY_EN is defined
module reduce_stream #(
    parameter int PORT_NUM = 2,
    parameter int WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PORT_NUM*WIDTH-1:0] in_data,
    input  logic [1:0]                in_op,
    input  logic                      in_last,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [7:0]                out_beats,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef REDUCE_STREAM_PARITY_EN
    ,
    output logic                      out_parity
`endif
);
    typedef enum logic {IDLE, OPEN} state_t;
    state_t state, state_next;
    logic [WIDTH-1:0] acc, acc_next, beat, and_v, or_v, xor_v, rand_v;
    logic [1:0] op_r, op_eff;
    logic [7:0] cnt, cnt_next;
    logic accept;
    always_comb begin
        and_v  = '1;
        or_v   = '0;
        xor_v  = '0;
        rand_v = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            and_v = and_v & in_data[i*WIDTH +: WIDTH];
            or_v  = or_v  | in_data[i*WIDTH +: WIDTH];
            xor_v = xor_v ^ in_data[i*WIDTH +: WIDTH];
        end
        rand_v[0] = &in_data;
    end
    // The opcode latched at packet start governs every later beat of that packet.
    always_comb begin
        op_eff   = (state == IDLE) ? in_op : op_r;
        beat     = (op_eff == 2'b00) ? and_v :
                   (op_eff == 2'b01) ? or_v  :
                   (op_eff == 2'b10) ? xor_v : rand_v;
        // RAND partials are single-bit ANDs, so they fold with AND as well.
        acc_next = (state == IDLE)  ? beat :
                   (op_r == 2'b01) ? (acc | beat) :
                   (op_r == 2'b10) ? (acc ^ beat) : (acc & beat);
        cnt_next = (state == IDLE) ? 8'd1 : (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end
    always_comb begin
        state_next = state;
        if (accept)
            state_next = in_last ? IDLE : OPEN;
    end
    always_comb begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            op_r      <= 2'b00;
            out_data  <= '0;
            out_beats <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                if (state == IDLE)
                    op_r <= in_op;
                if (in_last) begin
                    out_data  <= acc_next;
                    out_beats <= cnt_next;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt_next;
                end
            end
        end
    end
`ifdef REDUCE_STREAM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_parity <= 1'b0;
        else if (accept && in_last)
            out_parity <= ^acc_next;
    end
`endif
endmodule

// File: doc/reduce_stream.md
# reduce_stream

Streaming, parametrised successor to the 8-port combinational AND reducer. It accepts PORT_NUM operand words per beat over a valid/ready handshake and reduces them bitwise with a selectable operator (AND, OR, XOR, or full AND-reduce to one bit). It folds successive beats into a running accumulator until a beat marked last, then presents one registered result with a beat count. It sits between operand sources and any downstream consumer that needs packet-level reduction, with back-pressure.

## Interface
- PORT_NUM, 2, operand ports per beat; legal 2..8
- WIDTH, 8, bits per operand and result; legal 1..32
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  PORT_NUM*WIDTH  packed operands; port i = in_data[i*WIDTH +: WIDTH]
- in_op  in  2  00 AND, 01 OR, 10 XOR, 11 RAND (AND of every bit of every port, 1-bit)
- in_last  in  1  beat closes the current packet
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- out_data  out  WIDTH  packet result
- out_beats  out  8  beats in packet, saturating at 255
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result

## Operation
- Beat value B: AND/OR/XOR of all PORT_NUM ports bit-by-bit (WIDTH bits); RAND gives {WIDTH-1 zeros, &in_data}.
- State: IDLE (no open packet) and OPEN (accumulator holds partial result). Internal regs: acc[WIDTH-1:0], op_r[1:0], cnt[7:0].
- Accepted beat in IDLE: op_r <= in_op; acc_next = B; cnt_next = 1.
- Accepted beat in OPEN: acc_next = op_r(acc, B) (RAND folds with AND); cnt_next = sat255(cnt+1). in_op ignored mid-packet; B computed with op_r.
- Accepted beat with in_last=0: acc <= acc_next, cnt <= cnt_next, state OPEN.
- Accepted beat with in_last=1: out_data <= acc_next, out_beats <= cnt_next, out_valid <= 1, state IDLE, acc/cnt cleared to 0. Single-beat packets (last in IDLE) legal.
- in_ready = !out_valid || out_ready, for all beats, last or not (combinational from out_ready; no combinational path from in_valid).
- out_valid clears on out_valid && out_ready unless a last beat is accepted the same cycle, in which case out_valid stays 1 and output loads the new result.
- out_data/out_beats stable while out_valid && !out_ready.

## Timing
- Reset (asynchronous assert, synchronous release): out_valid 0, out_data 0, out_beats 0, acc 0, cnt 0, op_r 00, state IDLE. in_ready reads 1 during reset.
- Latency: last beat accepted at edge k -> out_valid 1 from edge k; data valid same cycle.
- Throughput: one beat per cycle; back-to-back single-beat packets sustained when out_ready=1.
- Reset mid-packet discards the open packet and any pending result; no partial output.
- in_valid=0 cycles inside a packet leave acc/cnt unchanged.
- cnt saturates at 255; accumulation continues correctly beyond 255 beats.

## Configuration
- REDUCE_STREAM_PARITY_EN defined: extra port out_parity (out, 1) = ^out_data, registered with out_data, reset 0, held under stall.
- Undefined: port absent; all other behaviour identical.

## Test plan
- PORT_NUM=2, WIDTH=7, op AND, single beat {7'h7F,7'h55}, last -> next cycle out_data 7'h55, out_beats 1, out_valid 1.
- Op XOR, 3-beat packet, beats {7'h01,7'h02},{7'h04,7'h00},{7'h08,7'h08} -> out_data 7'h07, out_beats 3; in_op changed to OR on beat 2 has no effect.
- Op RAND, beats {7'h7F,7'h7F} then {7'h7F,7'h7E} last -> out_data 7'h00; all-7'h7F repeat -> 7'h01.
- Stall: result held with out_ready=0 -> in_ready 0, new beat ignored, out_data unchanged; raise out_ready with a valid last beat same cycle -> new result loaded, out_valid stays 1.
- 300-beat OR packet -> out_beats 255, out_data correct OR of all beats.
- Assert rst_n low after 2 beats of open packet -> out_valid 0, out_beats 0; next single-beat packet reports out_beats 1.
